// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder family.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} adder_op_t;

  function automatic int chunk_w(input int n, input int s);
    return n / s;
  endfunction

endpackage

// File: rtl/adder_n.sv
// Combinational N-bit adder with carry in/out; one instance per pipeline chunk.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined N-bit add/subtract split into S carry-registered chunks,
// with a valid/ready handshake and a global stall on output back-pressure.
module adder_pipe_n
  import adder_pkg::*;
#(
  parameter int N = 32,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int W = chunk_w(N, S);

  if ((N % S) != 0) begin : g_bad_cfg
    $fatal(1, "adder_pipe_n: N must be a multiple of S");
  end

  logic         w_sub;
  logic         w_c_eff;
  logic         w_advance;
  logic [N-1:0] w_b_eff;

  assign w_sub     = (op == OP_SUB);
  assign w_b_eff   = w_sub ? ~b : b;
  assign w_c_eff   = c_in ^ w_sub;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [W-1:0]       w_ca;
    logic [W-1:0]       w_cb;
    logic [W-1:0]       w_cs;
    logic               w_ci;
    logic               w_vi;
    logic               w_co;
    logic [(k+1)*W-1:0] w_sum_nx;
    logic               r_vld;
    logic               r_c;
    logic [(k+1)*W-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_ca     = a[W-1:0];
      assign w_cb     = w_b_eff[W-1:0];
      assign w_ci     = w_c_eff;
      assign w_vi     = in_valid;
      assign w_sum_nx = w_cs;
    end else begin : g_body
      assign w_ca     = g_stage[k-1].g_skew.r_a_hi[W-1:0];
      assign w_cb     = g_stage[k-1].g_skew.r_b_hi[W-1:0];
      assign w_ci     = g_stage[k-1].r_c;
      assign w_vi     = g_stage[k-1].r_vld;
      assign w_sum_nx = {w_cs, g_stage[k-1].r_sum};
    end

    adder_n #(.N(W)) u_add (
      .a     (w_ca),
      .b     (w_cb),
      .c_in  (w_ci),
      .sum   (w_cs),
      .c_out (w_co)
    );

    // Valid, chunk carry and the growing deskewed sum move together.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_advance) begin
        r_vld <= w_vi;
        r_c   <= w_co;
        r_sum <= w_sum_nx;
      end
    end

    // Upper operand chunks still waiting for their stage ride along here.
    if (k < S - 1) begin : g_skew
      localparam int HW = N - (k + 1) * W;
      logic [HW-1:0] w_a_fw;
      logic [HW-1:0] w_b_fw;
      logic [HW-1:0] r_a_hi;
      logic [HW-1:0] r_b_hi;

      if (k == 0) begin : g_src_in
        assign w_a_fw = a[N-1:W];
        assign w_b_fw = w_b_eff[N-1:W];
      end else begin : g_src_prev
        assign w_a_fw = g_stage[k-1].g_skew.r_a_hi[HW+W-1:W];
        assign w_b_fw = g_stage[k-1].g_skew.r_b_hi[HW+W-1:W];
      end

      // Skew registers share the global stall with the rest of the stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_hi <= '0;
          r_b_hi <= '0;
        end else if (w_advance) begin
          r_a_hi <= w_a_fw;
          r_b_hi <= w_b_fw;
        end
      end
    end

    if (k == S - 1) begin : g_tail
      logic r_ovf;

      // Sign bits of a and b_eff arrive with the top chunk.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= (w_ca[W-1] == w_cb[W-1]) && (w_cs[W-1] != w_ca[W-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[S-1].r_vld;
  assign sum       = g_stage[S-1].r_sum;
  assign c_out     = g_stage[S-1].r_c;
  assign ovf       = g_stage[S-1].g_tail.r_ovf;

endmodule
